rr_encoder: RTL
===============

# rr_encoder

Registered 4-to-2 round-robin request encoder; the inverse of the team's 2-to-4 decoder. It collects one-hot or multi-hot request lines into a pending mask. It then emits one binary index at a time over a valid/ready handshake, rotating priority so no requester starves. It sits in front of the decoder: the encoded index travels on a narrow bus, and the decoder re-expands it into a one-hot select at the far end.

## Interface
- N, 4, number of request lines; must be a power of two, ≥ 2.
- W, $clog2(N), width of the encoded index.

- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request lines, sampled every rising edge; a 1 on bit i sets pending[i].
- Y    output W  encoded index of the granted request; held stable while valid=1 and ready=0.
- valid  output 1  Y holds a granted index.
- ready  input  1  consumer accepts Y on a rising edge where valid=1 and ready=1.
- pend_cnt  output W+1  population count of the pending mask, excluding the index currently presented on Y.

## Operation
- Registers:
  - pending[N-1:0]
  - last[W-1:0], the last granted index
  - the output register Y/valid
- The output register forms a two-state FSM:
  - EMPTY (valid=0), FULL (valid=1).
  - Output slot is free when state=EMPTY, or when state=FULL and ready=1 (accept).
  - EMPTY→FULL: slot free and cand≠0. Load Y with the picked index, set last to the picked index.
  - FULL→FULL: accept and cand≠0. Back-to-back grant; load the new index.
  - FULL→EMPTY: accept and cand=0.
  - FULL holds: ready=0. Y, valid and last do not change.
- Candidate mask: cand = pending | req. This is a combinational bypass: a request seen at an edge can be granted at that same edge.
- Pick: scan cand starting at index (last+1) mod N, moving upward with wrap-around. The first set bit wins.
- Pending update: pending_next = cand & ~grant_onehot. grant_onehot is zero when no load occurs.
- A req bit asserted on the same edge that grants that index is absorbed by the grant and does not re-pend.
- A req held high across several edges re-pends after each grant. A level request is therefore served once per rotation.
- Repeated req pulses on an index that is already pending merge; they are not counted twice.
- pend_cnt is popcount(pending), registered, so it tracks the pending mask after each edge.

## Timing
- Reset values:
  - Y=0, valid=0, state=EMPTY, pending=0, pend_cnt=0.
  - last=N-1, so index 0 has first priority after reset.
- Latency: req[i] sampled at edge k while the slot is free gives valid=1 and Y=i immediately after edge k (1 cycle).
- Throughput: one grant per cycle while ready=1 and requests remain.
- Handshake:
  - valid never drops without an accept.
  - Y never changes while valid=1 and ready=0.
  - ready while valid=0 has no effect.
- Reset asserted mid-operation: all registers return to reset values asynchronously. Pending requests and any un-accepted Y are discarded.
- Reset deassertion: the first edge with rst=0 samples req normally.

## Structure
- Shared package rr_encoder_pkg holds:
  - localparam defaults N_DEF=4 and W_DEF=2
  - the FSM enum state_t {EMPTY, FULL}
  - a popcount function reused by pend_cnt
- One combinational sub-module, rr_pick (inputs: cand, last; outputs: idx, onehot, any). It isolates the rotating priority scan so it can be unit-tested separately.
- The top level holds only registers, the FSM and pending bookkeeping.

## Test plan
- Reset: drive rst=1 with req=4'b1111, then release. Required: during reset valid=0, Y=0, pend_cnt=0. On the first edge after release, Y=0, valid=1 and pend_cnt=3.
- Rotation: ready=1, single-edge pulse req=4'b1111. Required: Y=0,1,2,3 on four consecutive cycles, then valid=0. pend_cnt reads 3,2,1,0.
- Stall: req=4'b0100 pulse, ready=0 for 5 cycles. Required: Y=2 with valid=1 held all 5 cycles, and no change when req=4'b0001 pulses during the stall. After ready=1, Y=0 on the following cycle.
- Fairness: req held at 4'b1001, ready=1. Required: Y alternates 0,3,0,3…; index 3 is never skipped.
- Same-edge absorb: slot free, pending=0, req=4'b0010 for exactly one edge. Required: Y=1 is granted once and pending[1] stays 0, so there is no second grant of index 1.
- Async reset mid-stream: with valid=1, Y=2 and pend_cnt=2, pulse rst between clock edges. Required: valid=0 and pend_cnt=0 immediately, without waiting for an edge. After release with req=4'b0100, Y=2 is granted first (last reset to 3).

Source files
------------

// File: rtl/rr_encoder_pkg.sv
// Shared definitions for the round-robin request encoder: default sizes,
// output-slot FSM encoding and a popcount helper.
package rr_encoder_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Wide enough for any mask this block will ever be built with.
  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rr_encoder_pick.sv
// Rotating-priority scan: first set bit of cand at or above (last+1) mod N,
// wrapping upward.
module rr_pick
  import rr_encoder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any
);

  logic [W-1:0] scan;

  // N is a power of two, so W-bit addition wraps exactly mod N; k=N lands on last.
  always_comb begin
    idx    = '0;
    onehot = '0;
    any    = 1'b0;
    scan   = '0;
    for (int k = 1; k <= N; k++) begin
      scan = last + W'(k);
      if (!any && cand[scan]) begin
        any          = 1'b1;
        idx          = scan;
        onehot[scan] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_encoder.sv
// Registered N-to-log2(N) round-robin request encoder with a valid/ready
// output slot and a pending-request mask.
module rr_encoder
  import rr_encoder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [W-1:0] Y,
  output logic         valid,
  input  logic         ready,
  output logic [W:0]   pend_cnt
);

  state_t       state, state_next;
  logic [N-1:0] pending, pending_next;
  logic [N-1:0] cand;
  logic [W-1:0] last;
  logic [W-1:0] pick_idx;
  logic [N-1:0] pick_onehot;
  logic         pick_any;
  logic         slot_free;
  logic         load;
  logic [N-1:0] grant_vec;

  // Same-edge requests bypass the pending register so they can be granted at once.
  assign cand = pending | req;

  rr_pick #(.N(N), .W(W)) u_pick (
    .cand   (cand),
    .last   (last),
    .idx    (pick_idx),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

  assign slot_free    = (state == EMPTY) || ready;
  assign load         = slot_free && pick_any;
  assign grant_vec    = load ? pick_onehot : '0;
  assign pending_next = cand & ~grant_vec;
  assign valid        = (state == FULL);

  always_comb begin
    state_next = state;
    if (slot_free) state_next = pick_any ? FULL : EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      pending  <= '0;
      pend_cnt <= '0;
      Y        <= '0;
      last     <= W'(N - 1);
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      pend_cnt <= (W+1)'(popcount(64'(pending_next)));
      if (load) begin
        Y    <= pick_idx;
        last <= pick_idx;
      end
    end
  end

endmodule
